// File: rtl/stim_gen.sv
// Pseudorandom operand source: Galois LFSR operands over valid/ready, with a
// latency-matched chk_valid strobe and a fixed per-run vector budget.
module stim_gen #(
    parameter int          AWIDTH      = 32,
    parameter int          BWIDTH      = 16,
    parameter int          NUM_VECTORS = 256,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] SEED        = 32'h00000001
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    input  logic              out_ready,
    output logic [AWIDTH-1:0] a,
    output logic [BWIDTH-1:0] b,
    output logic              out_valid,
    output logic              chk_valid,
    output logic [15:0]       vec_count,
    output logic              busy,
    output logic              done,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] MASK       = 32'h80200003;
    localparam logic [31:0] SEED_EFF   = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [15:0] LAST_VEC   = 16'(NUM_VECTORS - 1);
    localparam logic [4:0]  LAST_DRAIN = 5'(LATENCY - 1);

    state_t             state;
    state_t             next_state;
    logic [31:0]        lfsr;
    logic [31:0]        lfsr_next;
    logic [15:0]        fold;
    logic [4:0]         drain_cnt;
    logic [LATENCY-1:0] dly;
    logic               xfer;
    logic               launch;

    // Handshake: a word moves when out_valid & out_ready at a rising edge;
    // once out_valid is up, a/b/out_valid hold until that transfer happens.
    assign xfer   = out_valid & out_ready;
    assign launch = ((state == S_IDLE) || (state == S_DONE)) && start;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) next_state = S_RUN;
            end
            S_RUN: begin
                if (xfer && (vec_count == LAST_VEC)) next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_cnt == LAST_DRAIN) next_state = S_DONE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_RUN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign fsm_state = state;

    always_comb begin
        lfsr_next = lfsr >> 1;
        if (lfsr[0]) lfsr_next = (lfsr >> 1) ^ MASK;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            lfsr      <= SEED_EFF;
            vec_count <= 16'd0;
            drain_cnt <= 5'd0;
            dly       <= '0;
        end else begin
            // Shift register keeps every transfer gap intact at the far end.
            dly[0] <= xfer;
            for (int i = 1; i < LATENCY; i++) begin
                dly[i] <= dly[i-1];
            end
            if (launch) begin
                lfsr      <= SEED_EFF;
                vec_count <= 16'd0;
            end else if (xfer) begin
                lfsr      <= lfsr_next;
                vec_count <= vec_count + 16'd1;
            end
            if (state == S_DRAIN) begin
                drain_cnt <= drain_cnt + 5'd1;
            end else begin
                drain_cnt <= 5'd0;
            end
        end
    end

    assign fold      = lfsr[15:0] ^ lfsr[31:16];
    assign a         = lfsr[AWIDTH-1:0];
    assign b         = fold[BWIDTH-1:0];
    assign chk_valid = dly[LATENCY-1];

endmodule

// File: tb/tb_stim_gen.sv
// Directed bench for stim_gen: one instance with an 8-vector/latency-1 run
// (operand stream via expected queue) and one with a 4-vector/latency-3 run.
module tb_stim_gen;

    logic        clk;
    logic        rst_n;

    logic        start_a, ready_a;
    logic [31:0] a_a;
    logic [15:0] b_a;
    logic        out_valid_a, chk_valid_a, busy_a, done_a;
    logic [15:0] vec_count_a;
    logic [1:0]  fsm_state_a;

    logic        start_b, ready_b;
    logic [31:0] a_b;
    logic [15:0] b_b;
    logic        out_valid_b, chk_valid_b, busy_b, done_b;
    logic [15:0] vec_count_b;
    logic [1:0]  fsm_state_b;

    int          n_vec;
    int          n_err;
    logic [47:0] exp_q[$];
    logic [47:0] exp_e;
    logic        prev_xfer_a;

    // First eight {a, b} words from seed 1, worked by hand from the LFSR rule.
    logic [47:0] vec_tab [0:7] = '{
        {32'h00000001, 16'h0001},
        {32'h80200003, 16'h8023},
        {32'hC0300002, 16'hC032},
        {32'h60180001, 16'h6019},
        {32'hB02C0003, 16'hB02F},
        {32'hD8360002, 16'hD834},
        {32'h6C1B0001, 16'h6C1A},
        {32'hB62D8003, 16'h362E}
    };

    // Latency-3 run, one entry per cycle after the start edge:
    // {out_valid, chk_valid, busy, done}, then vec_count.
    logic [3:0]  flags_tab [0:8] = '{4'b1010, 4'b1010, 4'b1010, 4'b1110,
                                     4'b0110, 4'b0110, 4'b0110, 4'b0001, 4'b0001};
    logic [15:0] count_tab [0:8] = '{16'd0, 16'd1, 16'd2, 16'd3,
                                     16'd4, 16'd4, 16'd4, 16'd4, 16'd4};

    stim_gen #(.NUM_VECTORS(8), .LATENCY(1)) dut_a (
        .Clk       (clk),
        .Rst       (rst_n),
        .start     (start_a),
        .out_ready (ready_a),
        .a         (a_a),
        .b         (b_a),
        .out_valid (out_valid_a),
        .chk_valid (chk_valid_a),
        .vec_count (vec_count_a),
        .busy      (busy_a),
        .done      (done_a),
        .fsm_state (fsm_state_a)
    );

    stim_gen #(.NUM_VECTORS(4), .LATENCY(3)) dut_b (
        .Clk       (clk),
        .Rst       (rst_n),
        .start     (start_b),
        .out_ready (ready_b),
        .a         (a_b),
        .b         (b_b),
        .out_valid (out_valid_b),
        .chk_valid (chk_valid_b),
        .vec_count (vec_count_b),
        .busy      (busy_b),
        .done      (done_b),
        .fsm_state (fsm_state_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    // driver tasks
    task automatic pulse_start_a();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
    endtask

    task automatic pulse_start_b();
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
    endtask

    task automatic load_exp();
        for (int i = 0; i < 8; i++) exp_q.push_back(vec_tab[i]);
    endtask

    task automatic wait_done_a(input int max_cycles);
        for (int i = 0; i < max_cycles && !done_a; i++) @(negedge clk);
        check("done_a", done_a, 1);
        check("busy_end_a", busy_a, 0);
        check("count_end_a", vec_count_a, 8);
        check("queue_left_a", exp_q.size(), 0);
    endtask

    // scoreboard for instance a: operand stream, hold, and chk_valid timing
    always @(negedge clk) begin
        if (rst_n) begin
            check("chk_a", chk_valid_a, prev_xfer_a);
            check("busy_done_a", busy_a & done_a, 0);
            if (out_valid_a && ready_a) begin
                if (exp_q.size() == 0) begin
                    check("xfer_unexp_a", exp_q.size(), 1);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("ab_a", {a_a, b_a}, exp_e);
                end
            end else if (out_valid_a && exp_q.size() > 0) begin
                check("hold_a", {a_a, b_a}, exp_q[0]);
            end
            prev_xfer_a = out_valid_a & ready_a;
        end else begin
            prev_xfer_a = 1'b0;
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        prev_xfer_a = 1'b0;
        rst_n = 1'b0;
        start_a = 1'b0;
        ready_a = 1'b0;
        start_b = 1'b0;
        ready_b = 1'b0;

        // reset held with start toggling
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_a", {out_valid_a, chk_valid_a, busy_a, done_a, vec_count_a}, 0);
            check("rst_b", {out_valid_b, chk_valid_b, busy_b, done_b, vec_count_b}, 0);
            #1;
            start_a = ~start_a;
            start_b = ~start_b;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;

        // run a: one transfer, three stalled cycles, then the rest
        load_exp();
        ready_a = 1'b1;
        pulse_start_a();
        @(posedge clk); #1 ready_a = 1'b0;
        @(negedge clk);
        check("stall_count_a", vec_count_a, 1);
        repeat (3) @(posedge clk);
        #1 ready_a = 1'b1;
        wait_done_a(40);

        // second run from DONE with start pulses during RUN
        load_exp();
        pulse_start_a();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        wait_done_a(40);

        // run b: latency 3, cycle-by-cycle flags
        ready_b = 1'b1;
        pulse_start_b();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            check("flags_b", {out_valid_b, chk_valid_b, busy_b, done_b}, flags_tab[c]);
            check("count_b", vec_count_b, count_tab[c]);
            if (c == 0) check("first_a_b", a_b, 32'h00000001);
        end

        // run b aborted by reset after two transfers
        pulse_start_b();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_count_b", vec_count_b, 16'(c));
        end
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("abort_rst_b", {out_valid_b, chk_valid_b, busy_b, done_b, vec_count_b}, 0);
        check("abort_state_b", fsm_state_b, 0);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("abort_chk_b", chk_valid_b, 0);
        end
        pulse_start_b();
        @(negedge clk);
        check("restart_valid_b", out_valid_b, 1);
        check("restart_ab_b", {a_b, b_b}, {32'h00000001, 16'h0001});
        repeat (10) @(negedge clk);
        check("restart_done_b", done_b, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stim_gen.md
Name: stim_gen

Overview:
- Pseudorandom operand source for the self-checking benches. It is the producing end of the valid/compare path whose consuming end is error_monitor.
- Drives operands a/b to the reference and autogen circuits through a valid/ready handshake.
- Emits chk_valid aligned to circuit latency for error_monitor, counts transferred vectors, and flags done after a fixed vector budget.
- Synthesizable RTL, so benches and FPGA self-test share it.

Parameters:
- AWIDTH, 32, width of operand a (1..32).
- BWIDTH, 16, width of operand b (1..16).
- NUM_VECTORS, 256, vectors per run (1..65535).
- LATENCY, 1, cycles from operand transfer to chk_valid (1..16).
- SEED, 32'h00000001, LFSR load value; 0 is replaced by 1.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  synchronous reset, active-low (0 = reset).
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- out_ready  in  1  consumer accepts operands this cycle.
- a  out  AWIDTH  operand a.
- b  out  BWIDTH  operand b.
- out_valid  out  1  a/b valid.
- chk_valid  out  1  transfer pulse delayed LATENCY cycles.
- vec_count  out  16  vectors transferred this run.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.

Behaviour:
- Reset (Rst=0 at a Clk edge):
  - State goes to IDLE; lfsr=SEED (1 if SEED==0); vec_count=0; delay line cleared.
  - All outputs 0, except that a and b reflect the lfsr value and are don't-care while out_valid=0.
- Reset has priority over all other inputs at any state. Mid-run reset aborts the run; pending chk_valid pulses are discarded.
- LFSR: 32-bit Galois, right shift, mask 32'h80200003.
  - next = lsb ? (s>>1)^mask : (s>>1).
  - a = s[AWIDTH-1:0].
  - b = (s[15:0]^s[31:16])[BWIDTH-1:0].
- Transfer = out_valid & out_ready. The LFSR advances only on a transfer.
- While out_valid=1 and out_ready=0, a, b and out_valid hold stable (no retraction).
- FSM IDLE:
  - out_valid=0.
  - On start: reload lfsr=SEED, clear vec_count, go to RUN.
  - out_valid rises the cycle after start.
- FSM RUN:
  - out_valid=1.
  - Each transfer increments vec_count.
  - On the transfer that makes vec_count==NUM_VECTORS, go to DRAIN; out_valid=0 the next cycle.
  - start is ignored.
- FSM DRAIN:
  - Counts LATENCY cycles, then goes to DONE, so the last chk_valid pulse is emitted before done rises.
  - start is ignored.
- FSM DONE:
  - done=1; vec_count holds its final value.
  - start behaves as in IDLE: full reseed, so every run is repeatable.
- chk_valid: a LATENCY-deep shift register fed by transfer. Transfer at edge k gives chk_valid=1 during the cycle after edge k+LATENCY-1. With LATENCY=1, this is the cycle after the transfer.
- Back-to-back transfers give contiguous chk_valid pulses. Gaps from out_ready=0 are reproduced exactly.
- busy = (RUN|DRAIN); done and busy are never both high.
- vec_count is 16 bits and never wraps, because NUM_VECTORS ≤ 65535.

Test Plan:
- Hold Rst=0 for 10 cycles with start toggling -> out_valid=0, chk_valid=0, done=0, busy=0, vec_count=0 throughout.
- SEED=1, out_ready=1, start pulse -> consecutive vectors:
  - (a,b) = (0x00000001, 0x0001)
  - then (0x80200003, 0x8023)
  - then (0xC0300002, 0xC032)
  - chk_valid high one cycle after each transfer.
- out_ready low for 3 cycles while out_valid=1 -> a/b held at 0x80200003/0x8023; vec_count frozen; chk_valid shows a 3-cycle gap LATENCY cycles later.
- NUM_VECTORS=4, LATENCY=3, out_ready=1 ->
  - exactly 4 transfers; vec_count=4;
  - 4 chk_valid pulses, the last one 3 cycles after the final transfer;
  - done rises after it; busy falls with done rising.
- Second start from DONE -> same sequence as the first run, starting at a=0x00000001; start pulses during RUN have no effect.
- Rst=0 mid-run after 2 transfers -> next cycle all outputs 0, pending chk_valid pulses dropped, state IDLE; a new start restarts at a=0x00000001.
